store_queue: RTL and testbench

- In-order store buffer between dispatch/ROB and the data memory stage of the out-of-order RISC-V core.
- Allocates an entry per store at dispatch and captures address/data from the memory FU.
- Marks entries committed when the ROB retires them, then drains committed stores one per cycle to data memory as a store_wb pulse plus store fields.
- Supplies a combinational load-disambiguation signal so the memory FU holds a load while an older store is unresolved or overlaps it.

---
 rtl/store_queue.sv | 204 ++++++++++++++++++++
 tb/tb_store_queue.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
// In-order store buffer: allocates at dispatch, captures address/data from the memory FU,
// commits on ROB retire, drains one committed store per cycle, and flags loads that must wait.
module store_queue #(
    parameter int DEPTH  = 8,
    parameter int ROB_W  = 5,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_valid,
    input  logic [ROB_W-1:0]  disp_rob_tag,
    input  logic              disp_is_sh,
    output logic              full,
    input  logic              exec_valid,
    input  logic [ROB_W-1:0]  exec_rob_tag,
    input  logic [ADDR_W-1:0] exec_addr,
    input  logic [31:0]       exec_data,
    input  logic              retire_valid,
    input  logic [ROB_W-1:0]  retire_rob_tag,
    input  logic [ROB_W-1:0]  rob_head,
    input  logic              flush,
    input  logic              ld_check_valid,
    input  logic [ROB_W-1:0]  ld_rob_tag,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_is_byte,
    output logic              ld_block,
    output logic              store_wb,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [31:0]       wb_data,
    output logic              wb_is_sh,
    output logic [ROB_W-1:0]  wb_rob_tag,
    output logic              err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [ADDR_W:0]   SPAN_0   = '0;
    localparam logic [ADDR_W:0]   SPAN_1   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   SPAN_3   = (ADDR_W+1)'(3);

    logic [DEPTH-1:0]             valid_q, valid_d, addr_valid_q, addr_valid_d;
    logic [DEPTH-1:0]             committed_q, committed_d, is_sh_q, is_sh_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][31:0]       data_q, data_d;
    logic [DEPTH-1:0][ROB_W-1:0]  tag_q, tag_d;
    logic [PTR_W-1:0]             head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d, n_cmt;
    logic                         store_wb_q, store_wb_d, wb_is_sh_q, wb_is_sh_d, err_q, err_d;
    logic [ADDR_W-1:0]            wb_addr_q, wb_addr_d;
    logic [31:0]                  wb_data_q, wb_data_d;
    logic [ROB_W-1:0]             wb_rob_tag_q, wb_rob_tag_d;
    logic                         full_q, drain, alloc, ret_ok;

    assign full_q = (count_q == CNT_FULL);
    assign drain  = valid_q[head_q] && committed_q[head_q];
    assign ret_ok = valid_q[cmt_q] && addr_valid_q[cmt_q] && !committed_q[cmt_q]
                    && (tag_q[cmt_q] == retire_rob_tag);

    always_comb begin
        valid_d      = valid_q;
        addr_valid_d = addr_valid_q;
        committed_d  = committed_q;
        is_sh_d      = is_sh_q;
        addr_d       = addr_q;
        data_d       = data_q;
        tag_d        = tag_q;
        head_d       = head_q;
        cmt_d        = cmt_q;
        tail_d       = tail_q;
        count_d      = count_q;
        store_wb_d   = 1'b0;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        wb_is_sh_d   = wb_is_sh_q;
        wb_rob_tag_d = wb_rob_tag_q;
        err_d        = err_q;
        alloc        = 1'b0;
        n_cmt        = '0;

        if (drain) begin
            store_wb_d     = 1'b1;
            wb_addr_d      = addr_q[head_q];
            wb_data_d      = data_q[head_q];
            wb_is_sh_d     = is_sh_q[head_q];
            wb_rob_tag_d   = tag_q[head_q];
            valid_d[head_q] = 1'b0;
            head_d         = head_q + PTR_ONE;
        end

        if (retire_valid) begin
            if (ret_ok) begin
                committed_d[cmt_q] = 1'b1;
                cmt_d              = cmt_q + PTR_ONE;
            end else begin
                err_d = 1'b1;
            end
        end

        if (flush) begin
            // Committing happens first, so a store retiring this cycle is kept.
            for (int i = 0; i < DEPTH; i++) begin
                if (!committed_d[i]) valid_d[i] = 1'b0;
                if (valid_d[i] && committed_d[i]) n_cmt = n_cmt + CNT_ONE;
            end
            tail_d  = cmt_d;
            count_d = n_cmt;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (exec_valid && valid_q[i] && !committed_q[i] && tag_q[i] == exec_rob_tag) begin
                    addr_d[i]       = exec_addr;
                    data_d[i]       = exec_data;
                    addr_valid_d[i] = 1'b1;
                end
            end
            if (disp_valid) begin
                if (full_q) begin
                    err_d = 1'b1;
                end else begin
                    alloc                = 1'b1;
                    valid_d[tail_q]      = 1'b1;
                    addr_valid_d[tail_q] = 1'b0;
                    committed_d[tail_q]  = 1'b0;
                    is_sh_d[tail_q]      = disp_is_sh;
                    tag_d[tail_q]        = disp_rob_tag;
                    tail_d               = tail_q + PTR_ONE;
                end
            end
            if (alloc && !drain) count_d = count_q + CNT_ONE;
            if (!alloc && drain) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            addr_valid_q <= '0;
            committed_q  <= '0;
            is_sh_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            tag_q        <= '0;
            head_q       <= '0;
            cmt_q        <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            store_wb_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            wb_is_sh_q   <= 1'b0;
            wb_rob_tag_q <= '0;
            err_q        <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            addr_valid_q <= addr_valid_d;
            committed_q  <= committed_d;
            is_sh_q      <= is_sh_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            tag_q        <= tag_d;
            head_q       <= head_d;
            cmt_q        <= cmt_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            store_wb_q   <= store_wb_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            wb_is_sh_q   <= wb_is_sh_d;
            wb_rob_tag_q <= wb_rob_tag_d;
            err_q        <= err_d;
        end
    end

    // Load disambiguation: ages are distances from the ROB head; sums are one bit wider so nothing wraps.
    logic [DEPTH-1:0] ld_hit;
    logic [ROB_W-1:0] ld_age;
    logic [ADDR_W:0]  l_lo, l_hi;

    assign ld_age = ld_rob_tag - rob_head;
    assign l_lo   = {1'b0, ld_addr};
    assign l_hi   = l_lo + (ld_is_byte ? SPAN_0 : SPAN_3);

    for (genvar g = 0; g < DEPTH; g++) begin : g_ld
        logic [ROB_W-1:0] s_age;
        logic [ADDR_W:0]  s_lo, s_hi;
        logic             older, overlap;
        assign s_age   = tag_q[g] - rob_head;
        assign s_lo    = {1'b0, addr_q[g]};
        assign s_hi    = s_lo + (is_sh_q[g] ? SPAN_1 : SPAN_3);
        assign older   = committed_q[g] || (s_age < ld_age);
        assign overlap = (s_lo <= l_hi) && (l_lo <= s_hi);
        assign ld_hit[g] = valid_q[g] && older && (!addr_valid_q[g] || overlap);
    end

    assign ld_block   = ld_check_valid && (|ld_hit);
    assign full       = full_q;
    assign store_wb   = store_wb_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign wb_is_sh   = wb_is_sh_q;
    assign wb_rob_tag = wb_rob_tag_q;
    assign err        = err_q;
endmodule

// File: tb/tb_store_queue.sv
// Store queue bench: directed scenarios plus randomized traffic, checked against a
// queue-based reference model of the store buffer.
module tb_store_queue;
    localparam int DEPTH = 8;
    localparam int ROB_W = 5;
    localparam int ADDR_W = 32;

    logic clk = 1'b0, reset = 1'b0;
    logic disp_valid = 0, disp_is_sh = 0, exec_valid = 0, retire_valid = 0, flush = 0;
    logic ld_check_valid = 0, ld_is_byte = 0;
    logic [ROB_W-1:0] disp_rob_tag = 0, exec_rob_tag = 0, retire_rob_tag = 0, rob_head = 0, ld_rob_tag = 0;
    logic [ADDR_W-1:0] exec_addr = 0, ld_addr = 0;
    logic [31:0] exec_data = 0;
    logic full, ld_block, store_wb, wb_is_sh, err;
    logic [ADDR_W-1:0] wb_addr;
    logic [31:0] wb_data;
    logic [ROB_W-1:0] wb_rob_tag;

    store_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_rob_tag(disp_rob_tag), .disp_is_sh(disp_is_sh), .full(full),
        .exec_valid(exec_valid), .exec_rob_tag(exec_rob_tag), .exec_addr(exec_addr), .exec_data(exec_data),
        .retire_valid(retire_valid), .retire_rob_tag(retire_rob_tag), .rob_head(rob_head), .flush(flush),
        .ld_check_valid(ld_check_valid), .ld_rob_tag(ld_rob_tag), .ld_addr(ld_addr), .ld_is_byte(ld_is_byte),
        .ld_block(ld_block), .store_wb(store_wb), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_is_sh(wb_is_sh), .wb_rob_tag(wb_rob_tag), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROB_W-1:0]  tag;
        bit                av;
        bit                cm;
        bit                sh;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } ent_t;

    ent_t mq[$];
    bit e_wb, e_sh, e_err;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0] e_data;
    logic [ROB_W-1:0] e_tag;
    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_ld_block();
        logic [ROB_W-1:0] la, sa;
        longint slo, shi, llo, lhi;
        if (!ld_check_valid) return 1'b0;
        la  = ld_rob_tag - rob_head;
        llo = longint'(ld_addr);
        lhi = llo + (ld_is_byte ? 0 : 3);
        foreach (mq[i]) begin
            sa = mq[i].tag - rob_head;
            if (mq[i].cm || sa < la) begin
                if (!mq[i].av) return 1'b1;
                slo = longint'(mq[i].addr);
                shi = slo + (mq[i].sh ? 1 : 3);
                if (slo <= lhi && llo <= shi) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        e_wb = 0; e_sh = 0; e_err = 0; e_addr = 0; e_data = 0; e_tag = 0;
    endtask

    task automatic model_edge();
        bit drn, was_full, rok;
        int ci;
        ent_t keep[$];
        ent_t e;
        drn      = (mq.size() > 0) && mq[0].cm;
        was_full = (mq.size() == DEPTH);
        ci = -1;
        foreach (mq[i]) if (ci < 0 && !mq[i].cm) ci = i;
        rok = retire_valid && ci >= 0 && mq[ci].av && mq[ci].tag == retire_rob_tag;
        if (retire_valid && !rok) e_err = 1;
        if (!flush && exec_valid)
            foreach (mq[i])
                if (!mq[i].cm && mq[i].tag == exec_rob_tag) begin
                    mq[i].av = 1; mq[i].addr = exec_addr; mq[i].data = exec_data;
                end
        if (rok) mq[ci].cm = 1;
        if (flush) begin
            foreach (mq[i]) if (mq[i].cm) keep.push_back(mq[i]);
            mq = keep;
        end else if (disp_valid) begin
            if (was_full) e_err = 1;
            else begin
                e.tag = disp_rob_tag; e.av = 0; e.cm = 0; e.sh = disp_is_sh; e.addr = 0; e.data = 0;
                mq.push_back(e);
            end
        end
        if (drn) begin
            e_wb = 1; e_addr = mq[0].addr; e_data = mq[0].data; e_sh = mq[0].sh; e_tag = mq[0].tag;
            void'(mq.pop_front());
        end else e_wb = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        chk("ld_block", ld_block, model_ld_block());
        chk("full_pre", full, mq.size() == DEPTH);
        @(posedge clk);
        model_edge();
        #1;
        chk("store_wb", store_wb, e_wb);
        chk("wb_addr", wb_addr, e_addr);
        chk("wb_data", wb_data, e_data);
        chk("wb_is_sh", wb_is_sh, e_sh);
        chk("wb_rob_tag", wb_rob_tag, e_tag);
        chk("err", err, e_err);
        chk("full", full, mq.size() == DEPTH);
        @(negedge clk);
        disp_valid = 0; exec_valid = 0; retire_valid = 0; flush = 0; ld_check_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        model_reset();
        chk("rst_store_wb", store_wb, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_ld_block", ld_block, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_tag", wb_rob_tag, 0);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic disp(input logic [ROB_W-1:0] t, input bit sh);
        disp_valid = 1; disp_rob_tag = t; disp_is_sh = sh; tick();
    endtask
    task automatic exec(input logic [ROB_W-1:0] t, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exec_valid = 1; exec_rob_tag = t; exec_addr = a; exec_data = d; tick();
    endtask
    task automatic retire(input logic [ROB_W-1:0] t);
        retire_valid = 1; retire_rob_tag = t; tick();
    endtask
    task automatic ld_probe(input string tag, input logic [ROB_W-1:0] t, input logic [ADDR_W-1:0] a,
                            input bit byt, input bit exp);
        ld_check_valid = 1; ld_rob_tag = t; ld_addr = a; ld_is_byte = byt;
        #1;
        chk(tag, ld_block, exp);
        tick();
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        case ($urandom_range(0, 8))
            0: return 32'h100; 1: return 32'h101; 2: return 32'h102; 3: return 32'h103;
            4: return 32'h104; 5: return 32'h1FF; 6: return 32'h200; 7: return 32'hFFFF_FFFE;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [ROB_W-1:0] next_tag;
        int ci;
        @(negedge clk);
        do_reset();

        // Basic commit-to-drain latency.
        rob_head = 3;
        disp(3, 0);
        exec(3, 32'h100, 32'hDEAD_BEEF);
        retire(3);
        chk("t1_no_wb_after_n", store_wb, 0);
        tick();
        chk("t1_wb", store_wb, 1);
        chk("t1_addr", wb_addr, 32'h100);
        chk("t1_data", wb_data, 32'hDEAD_BEEF);
        chk("t1_sh", wb_is_sh, 0);
        tick();
        chk("t1_wb_off", store_wb, 0);

        // Fill, overflow, back-to-back drain with wrap.
        do_reset();
        rob_head = 0;
        for (int i = 0; i < 8; i++) disp(ROB_W'(i), 0);
        chk("t2_full", full, 1);
        disp(8, 0);
        chk("t2_err", err, 1);
        for (int i = 0; i < 8; i++) exec(ROB_W'(i), 32'h1000 + 32'(i * 4), 32'(i) * 32'h1111);
        for (int i = 0; i < 8; i++) begin
            rob_head = ROB_W'(i);
            retire(ROB_W'(i));
            if (i > 0) chk("t2_b2b_tag", wb_rob_tag, ROB_W'(i - 1));
        end
        tick();
        chk("t2_last_tag", wb_rob_tag, 7);
        chk("t2_last_wb", store_wb, 1);
        tick();
        chk("t2_not_full", full, 0);
        chk("t2_wb_off", store_wb, 0);

        // Disambiguation: unknown address, disjoint, sh/lbu neighbours.
        do_reset();
        rob_head = 0;
        disp(2, 0);
        ld_probe("t3_unres", 5, 32'h200, 0, 1);
        exec(2, 32'h300, 32'h1);
        ld_probe("t3_disjoint", 5, 32'h200, 0, 0);
        do_reset();
        disp(2, 1);
        exec(2, 32'h1FF, 32'h55);
        ld_probe("t3_sh_lbu_ovl", 5, 32'h200, 1, 1);
        ld_probe("t3_sh_lbu_clr", 5, 32'h201, 1, 0);

        // Age wraparound.
        do_reset();
        disp(4, 0);
        rob_head = 30;
        ld_probe("t4_younger_store", 1, 32'h40, 0, 0);
        rob_head = 3;
        ld_probe("t4_older_store", 30, 32'h40, 0, 1);

        // Retire and flush on the same edge.
        do_reset();
        rob_head = 1;
        disp(1, 0); disp(2, 0); disp(3, 1);
        exec(1, 32'h500, 32'hA1); exec(2, 32'h504, 32'hA2); exec(3, 32'h508, 32'hA3);
        retire_valid = 1; retire_rob_tag = 1; flush = 1; tick();
        tick();
        chk("t5_wb", store_wb, 1);
        chk("t5_tag", wb_rob_tag, 1);
        chk("t5_err", err, 0);
        exec(2, 32'h600, 32'hBB);
        rob_head = 5;
        disp(5, 0);
        ld_probe("t5_new_unres", 9, 32'h900, 0, 1);
        exec(5, 32'h700, 32'hCC);
        retire(5);
        tick();
        chk("t5_after_tag", wb_rob_tag, 5);
        chk("t5_after_data", wb_data, 32'hCC);

        // Retire protocol errors.
        do_reset();
        rob_head = 1;
        disp(1, 0); disp(2, 0);
        exec(2, 32'h80, 32'h1);
        retire(2);
        chk("t6_err_wrong", err, 1);
        tick();
        chk("t6_no_wb", store_wb, 0);
        do_reset();
        rob_head = 2;
        disp(2, 0);
        retire(2);
        chk("t6_err_noaddr", err, 1);
        tick();
        chk("t6_no_wb2", store_wb, 0);

        // Reset in the middle of a drain.
        do_reset();
        rob_head = 1;
        disp(1, 0); disp(2, 0);
        exec(1, 32'h10, 32'h1); exec(2, 32'h20, 32'h2);
        retire(1);
        rob_head = 2;
        retire(2);
        chk("t7_pulse", store_wb, 1);
        do_reset();
        tick();
        chk("t7_aborted", store_wb, 0);

        // Randomized traffic in blocks, each starting from reset.
        for (int blk = 0; blk < 15; blk++) begin
            do_reset();
            next_tag = ROB_W'($urandom);
            for (int cyc = 0; cyc < 200; cyc++) begin
                ci = -1;
                foreach (mq[i]) if (ci < 0 && !mq[i].cm) ci = i;
                rob_head = (ci >= 0) ? mq[ci].tag : next_tag;
                if ($urandom_range(0, 9) == 0) rob_head = ROB_W'($urandom);
                disp_valid = ($urandom_range(0, 2) == 0);
                disp_rob_tag = next_tag;
                disp_is_sh = $urandom_range(0, 1);
                if (disp_valid) next_tag = next_tag + 1'b1;
                exec_valid = $urandom_range(0, 1);
                exec_rob_tag = (mq.size() > 0 && $urandom_range(0, 4) != 0)
                               ? mq[$urandom_range(0, mq.size() - 1)].tag : ROB_W'($urandom);
                exec_addr = pick_addr();
                exec_data = $urandom;
                retire_valid = ($urandom_range(0, 9) < 3);
                retire_rob_tag = (ci >= 0 && $urandom_range(0, 19) != 0) ? mq[ci].tag : ROB_W'($urandom);
                flush = ($urandom_range(0, 32) == 0);
                ld_check_valid = ($urandom_range(0, 9) < 7);
                ld_rob_tag = rob_head + ROB_W'($urandom_range(0, 10));
                ld_addr = pick_addr();
                ld_is_byte = $urandom_range(0, 1);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
